// File: rtl/sw_encoder_db_pkg.sv
// ---------------------------------------------------------------------------
// sw_enc_pkg : shared types, defaults and priority encoder for sw_encoder_db
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sw_enc_pkg;

  typedef enum logic {DB_IDLE, DB_CHECK} db_state_t;

  localparam int SW_N_DEF  = 16;
  localparam int SW_DB_DEF = 500000;

  // Encoder works on a fixed maximum width; callers truncate the result
  localparam int ENC_MAX_N = 256;
  localparam int ENC_W     = 8;

  function automatic logic [ENC_W-1:0] prio_enc(input logic [ENC_MAX_N-1:0] vec,
                                                input int                   n,
                                                input bit                   prio_high);
    logic [ENC_W-1:0] idx;
    bit               found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < ENC_MAX_N; i++) begin
      if ((i < n) && vec[i] && (prio_high || !found)) begin
        idx   = ENC_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sw_encoder_db_if.sv
// ---------------------------------------------------------------------------
// sw_encoder_db_if : settled-change event channel (valid/ready + drop flag)
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sw_encoder_db_if #(
  parameter int ADDR_W = 4
) ();

  logic              evt_valid;
  logic [ADDR_W-1:0] evt_addr;
  logic              evt_ready;
  logic              evt_drop;

  modport master (output evt_valid, evt_addr, evt_drop, input  evt_ready);
  modport slave  (input  evt_valid, evt_addr, evt_drop, output evt_ready);

endinterface

`default_nettype wire

// File: rtl/sw_encoder_db_sync_debounce.sv
// ---------------------------------------------------------------------------
// sw_sync_debounce : 2-flop synchroniser plus debounce FSM for the switch bank
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sw_sync_debounce
  import sw_enc_pkg::*;
#(
  parameter int N_SW      = SW_N_DEF,
  parameter int DB_CYCLES = SW_DB_DEF
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic [N_SW-1:0] sw,
  output logic      [N_SW-1:0] sw_stable,
  output logic                 stable_chg
);

  localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  db_state_t        state_q, state_d;
  logic [N_SW-1:0]  sync1_q, sync2_q;
  logic [N_SW-1:0]  cand_q, cand_d;
  logic [N_SW-1:0]  stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             chg_q, chg_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DB_IDLE;
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      chg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sw;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      chg_q    <= chg_d;
    end
  end

  // cand always differs from stable while in CHECK, so every commit is a real change
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    chg_d    = 1'b0;
    case (state_q)
      DB_IDLE: begin
        if (sync2_q != stable_q) begin
          cand_d  = sync2_q;
          cnt_d   = '0;
          state_d = DB_CHECK;
        end
      end
      DB_CHECK: begin
        if (sync2_q != cand_q) begin
          cand_d = sync2_q;
          cnt_d  = '0;
          if (sync2_q == stable_q) state_d = DB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          stable_d = cand_q;
          chg_d    = 1'b1;
          state_d  = DB_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = DB_IDLE;
    endcase
  end

  assign sw_stable  = stable_q;
  assign stable_chg = chg_q;

endmodule

`default_nettype wire

// File: rtl/sw_encoder_db.sv
// ---------------------------------------------------------------------------
// sw_encoder_db : debounced switch bank -> priority address with change events
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sw_encoder_db
  import sw_enc_pkg::*;
#(
  parameter int N_SW      = SW_N_DEF,
  parameter int ADDR_W    = $clog2(N_SW),
  parameter int DB_CYCLES = SW_DB_DEF,
  parameter int PRIO_HIGH = 1
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic [N_SW-1:0]   sw,
  output logic      [ADDR_W-1:0] addr,
  output logic                   any_on,
  output logic      [N_SW-1:0]   sw_stable,
  sw_encoder_db_if.master        evt
);

  logic              stable_chg;
  logic [ADDR_W-1:0] enc;
  logic              accept;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              any_on_q, any_on_d;
  logic              evt_valid_q, evt_valid_d;
  logic [ADDR_W-1:0] evt_addr_q, evt_addr_d;
  logic              evt_drop_q, evt_drop_d;

  sw_sync_debounce #(
    .N_SW      (N_SW),
    .DB_CYCLES (DB_CYCLES)
  ) u_db (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .sw_stable  (sw_stable),
    .stable_chg (stable_chg)
  );

  assign enc    = ADDR_W'(prio_enc(ENC_MAX_N'(sw_stable), N_SW, PRIO_HIGH != 0));
  assign accept = evt_valid_q && evt.evt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      any_on_q    <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_addr_q  <= '0;
      evt_drop_q  <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      any_on_q    <= any_on_d;
      evt_valid_q <= evt_valid_d;
      evt_addr_q  <= evt_addr_d;
      evt_drop_q  <= evt_drop_d;
    end
  end

  // A new change always wins over a same-cycle accept; drop only flags true overwrites
  always_comb begin
    addr_d      = addr_q;
    any_on_d    = any_on_q;
    evt_valid_d = evt_valid_q;
    evt_addr_d  = evt_addr_q;
    evt_drop_d  = evt_drop_q;
    if (stable_chg) begin
      addr_d      = enc;
      any_on_d    = |sw_stable;
      evt_valid_d = 1'b1;
      evt_addr_d  = enc;
      if (evt_valid_q && !evt.evt_ready) evt_drop_d = 1'b1;
    end else if (accept) begin
      evt_valid_d = 1'b0;
      evt_drop_d  = 1'b0;
    end
  end

  assign addr          = addr_q;
  assign any_on        = any_on_q;
  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_addr  = evt_addr_q;
  assign evt.evt_drop  = evt_drop_q;

endmodule

`default_nettype wire

// File: tb/tb_sw_encoder_db.sv
// ---------------------------------------------------------------------------
// tb_sw_encoder_db : directed test of sw_encoder_db, high- and low-priority variants
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sw_encoder_db;

  localparam int N  = 16;
  localparam int AW = 4;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  sw = '0;
  logic [AW-1:0] addr_hi, addr_lo;
  logic          any_hi, any_lo;
  logic [N-1:0]  stab_hi, stab_lo;
  int            n_cmp = 0;
  int            n_err = 0;

  sw_encoder_db_if #(.ADDR_W(AW)) if_hi ();
  sw_encoder_db_if #(.ADDR_W(AW)) if_lo ();

  sw_encoder_db #(.N_SW(N), .ADDR_W(AW), .DB_CYCLES(DB), .PRIO_HIGH(1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .sw(sw), .addr(addr_hi), .any_on(any_hi),
    .sw_stable(stab_hi), .evt(if_hi.master));

  sw_encoder_db #(.N_SW(N), .ADDR_W(AW), .DB_CYCLES(DB), .PRIO_HIGH(0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .sw(sw), .addr(addr_lo), .any_on(any_lo),
    .sw_stable(stab_lo), .evt(if_lo.master));

  always #5 clk = ~clk;

  // Returns 1 ns after the n-th rising edge; all driving and sampling happens there
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic r);
    if_hi.evt_ready = r;
    if_lo.evt_ready = r;
  endtask

  task automatic test_reset();
    set_ready(1'b0);
    sw    = '0;
    rst_n = 1'b0;
    wait_edges(3);
    rst_n = 1'b1;
    wait_edges(1);
    n_cmp++; if (addr_hi !== 4'd0) begin n_err++; $display("FAIL rst_addr: got %0d want 0", addr_hi); end
    n_cmp++; if (any_hi !== 1'b0) begin n_err++; $display("FAIL rst_any_on: got %0d want 0", any_hi); end
    n_cmp++; if (stab_hi !== 16'h0) begin n_err++; $display("FAIL rst_sw_stable: got %h want 0000", stab_hi); end
    n_cmp++; if (if_hi.evt_addr !== 4'd0) begin n_err++; $display("FAIL rst_evt_addr: got %0d want 0", if_hi.evt_addr); end
    n_cmp++; if (if_hi.evt_drop !== 1'b0) begin n_err++; $display("FAIL rst_evt_drop: got %0d want 0", if_hi.evt_drop); end
    for (int i = 0; i < 12; i++) begin
      n_cmp++; if (if_hi.evt_valid !== 1'b0) begin n_err++; $display("FAIL rst_evt_valid cyc %0d: got %0d want 0", i, if_hi.evt_valid); end
      wait_edges(1);
    end
  endtask

  task automatic test_glitch();
    sw = 16'h0001;
    wait_edges(3);
    sw = 16'h0000;
    wait_edges(12);
    n_cmp++; if (stab_hi !== 16'h0) begin n_err++; $display("FAIL glitch_sw_stable: got %h want 0000", stab_hi); end
    n_cmp++; if (addr_hi !== 4'd0) begin n_err++; $display("FAIL glitch_addr: got %0d want 0", addr_hi); end
    n_cmp++; if (if_hi.evt_valid !== 1'b0) begin n_err++; $display("FAIL glitch_evt_valid: got %0d want 0", if_hi.evt_valid); end
  endtask

  task automatic test_latency();
    sw = 16'h0024;
    wait_edges(6);
    n_cmp++; if (stab_hi !== 16'h0000) begin n_err++; $display("FAIL lat_stable_early: got %h want 0000", stab_hi); end
    wait_edges(1);
    n_cmp++; if (stab_hi !== 16'h0024) begin n_err++; $display("FAIL lat_stable: got %h want 0024", stab_hi); end
    n_cmp++; if (addr_hi !== 4'd0) begin n_err++; $display("FAIL lat_addr_early: got %0d want 0", addr_hi); end
    n_cmp++; if (if_hi.evt_valid !== 1'b0) begin n_err++; $display("FAIL lat_valid_early: got %0d want 0", if_hi.evt_valid); end
    wait_edges(1);
    n_cmp++; if (addr_hi !== 4'd5) begin n_err++; $display("FAIL lat_addr_hi: got %0d want 5", addr_hi); end
    n_cmp++; if (any_hi !== 1'b1) begin n_err++; $display("FAIL lat_any_on: got %0d want 1", any_hi); end
    n_cmp++; if (if_hi.evt_valid !== 1'b1) begin n_err++; $display("FAIL lat_evt_valid: got %0d want 1", if_hi.evt_valid); end
    n_cmp++; if (if_hi.evt_addr !== 4'd5) begin n_err++; $display("FAIL lat_evt_addr: got %0d want 5", if_hi.evt_addr); end
    n_cmp++; if (addr_lo !== 4'd2) begin n_err++; $display("FAIL lat_addr_lo: got %0d want 2", addr_lo); end
    n_cmp++; if (if_lo.evt_addr !== 4'd2) begin n_err++; $display("FAIL lat_evt_addr_lo: got %0d want 2", if_lo.evt_addr); end
    set_ready(1'b1);
    wait_edges(1);
    set_ready(1'b0);
    n_cmp++; if (if_hi.evt_valid !== 1'b0) begin n_err++; $display("FAIL lat_accept_valid: got %0d want 0", if_hi.evt_valid); end
    n_cmp++; if (addr_hi !== 4'd5) begin n_err++; $display("FAIL lat_addr_hold: got %0d want 5", addr_hi); end
  endtask

  task automatic test_drop();
    sw = 16'h8000;
    wait_edges(8);
    n_cmp++; if (if_hi.evt_valid !== 1'b1) begin n_err++; $display("FAIL drop_valid1: got %0d want 1", if_hi.evt_valid); end
    n_cmp++; if (if_hi.evt_addr !== 4'd15) begin n_err++; $display("FAIL drop_evt_addr1: got %0d want 15", if_hi.evt_addr); end
    n_cmp++; if (if_hi.evt_drop !== 1'b0) begin n_err++; $display("FAIL drop_flag1: got %0d want 0", if_hi.evt_drop); end
    sw = 16'h8001;
    wait_edges(8);
    n_cmp++; if (stab_hi !== 16'h8001) begin n_err++; $display("FAIL drop_stable2: got %h want 8001", stab_hi); end
    n_cmp++; if (if_hi.evt_addr !== 4'd15) begin n_err++; $display("FAIL drop_evt_addr2: got %0d want 15", if_hi.evt_addr); end
    n_cmp++; if (if_hi.evt_drop !== 1'b1) begin n_err++; $display("FAIL drop_flag2: got %0d want 1", if_hi.evt_drop); end
    n_cmp++; if (if_lo.evt_addr !== 4'd0) begin n_err++; $display("FAIL drop_evt_addr_lo: got %0d want 0", if_lo.evt_addr); end
    n_cmp++; if (if_lo.evt_drop !== 1'b1) begin n_err++; $display("FAIL drop_flag_lo: got %0d want 1", if_lo.evt_drop); end
    set_ready(1'b1);
    wait_edges(1);
    set_ready(1'b0);
    n_cmp++; if (if_hi.evt_valid !== 1'b0) begin n_err++; $display("FAIL drop_accept_valid: got %0d want 0", if_hi.evt_valid); end
    n_cmp++; if (if_hi.evt_drop !== 1'b0) begin n_err++; $display("FAIL drop_accept_flag: got %0d want 0", if_hi.evt_drop); end
    set_ready(1'b1);
    wait_edges(2);
    set_ready(1'b0);
    n_cmp++; if (if_hi.evt_valid !== 1'b0) begin n_err++; $display("FAIL idle_ready_valid: got %0d want 0", if_hi.evt_valid); end
  endtask

  task automatic test_back_to_back();
    sw = 16'h0010;
    wait_edges(8);
    sw = 16'h0011;
    wait_edges(8);
    n_cmp++; if (if_hi.evt_drop !== 1'b1) begin n_err++; $display("FAIL b2b_setup_drop: got %0d want 1", if_hi.evt_drop); end
    n_cmp++; if (if_hi.evt_addr !== 4'd4) begin n_err++; $display("FAIL b2b_setup_addr: got %0d want 4", if_hi.evt_addr); end
    sw = 16'h0030;
    wait_edges(7);
    set_ready(1'b1);
    wait_edges(1);
    set_ready(1'b0);
    n_cmp++; if (if_hi.evt_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %0d want 1", if_hi.evt_valid); end
    n_cmp++; if (if_hi.evt_addr !== 4'd5) begin n_err++; $display("FAIL b2b_evt_addr: got %0d want 5", if_hi.evt_addr); end
    n_cmp++; if (if_hi.evt_drop !== 1'b1) begin n_err++; $display("FAIL b2b_drop: got %0d want 1", if_hi.evt_drop); end
    n_cmp++; if (if_lo.evt_addr !== 4'd4) begin n_err++; $display("FAIL b2b_evt_addr_lo: got %0d want 4", if_lo.evt_addr); end
    set_ready(1'b1);
    wait_edges(1);
    set_ready(1'b0);
    n_cmp++; if (if_hi.evt_valid !== 1'b0) begin n_err++; $display("FAIL b2b_clear_valid: got %0d want 0", if_hi.evt_valid); end
    n_cmp++; if (if_hi.evt_drop !== 1'b0) begin n_err++; $display("FAIL b2b_clear_drop: got %0d want 0", if_hi.evt_drop); end
  endtask

  task automatic test_reset_mid();
    sw = 16'h0100;
    wait_edges(4);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (addr_hi !== 4'd0) begin n_err++; $display("FAIL rmid_addr: got %0d want 0", addr_hi); end
    n_cmp++; if (any_hi !== 1'b0) begin n_err++; $display("FAIL rmid_any_on: got %0d want 0", any_hi); end
    n_cmp++; if (stab_hi !== 16'h0) begin n_err++; $display("FAIL rmid_stable: got %h want 0000", stab_hi); end
    n_cmp++; if (if_hi.evt_valid !== 1'b0) begin n_err++; $display("FAIL rmid_evt_valid: got %0d want 0", if_hi.evt_valid); end
    wait_edges(2);
    rst_n = 1'b1;
    wait_edges(7);
    n_cmp++; if (if_hi.evt_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid_early: got %0d want 0", if_hi.evt_valid); end
    n_cmp++; if (stab_hi !== 16'h0100) begin n_err++; $display("FAIL rmid_stable_new: got %h want 0100", stab_hi); end
    wait_edges(1);
    n_cmp++; if (addr_hi !== 4'd8) begin n_err++; $display("FAIL rmid_addr_new: got %0d want 8", addr_hi); end
    n_cmp++; if (if_hi.evt_valid !== 1'b1) begin n_err++; $display("FAIL rmid_valid_new: got %0d want 1", if_hi.evt_valid); end
    n_cmp++; if (if_hi.evt_addr !== 4'd8) begin n_err++; $display("FAIL rmid_evt_addr: got %0d want 8", if_hi.evt_addr); end
    n_cmp++; if (addr_lo !== 4'd8) begin n_err++; $display("FAIL rmid_addr_lo: got %0d want 8", addr_lo); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_latency();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
